umi_mux_rr: RTL and testbench

- N-input UMI multiplexer with fixed-priority or round-robin arbitration.
- Output-side ready/backpressure, with a one-entry registered output stage.
- Grant is locked across multi-beat transactions, delimited by a per-input last flag.
- Sits in front of a shared UMI port (crossbar column, host link egress). Used where the unregistered, no-backpressure fixed-priority mux is insufficient.

---
 rtl/umi_mux_rr.sv | 198 +++++++++++++++++++
 tb/tb_umi_mux_rr.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/umi_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : umi_mux_rr
// Purpose  : N-input UMI mux, fixed/round-robin arbitration, transaction lock,
//            one-entry registered output with backpressure. Optional
//            starvation override enabled by macro UMI_MUX_STARVE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module umi_mux_rr #(
    parameter int UW     = 256,
    parameter int N      = 4,
    parameter int STARVE = 16
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic [1:0]      mode,
    input  logic [N-1:0]    mask,
    input  logic [N-1:0]    umi_in_valid,
    input  logic [N-1:0]    umi_in_last,
    input  logic [N*UW-1:0] umi_in_packet,
    output logic [N-1:0]    umi_in_ready,
    output logic            umi_out_valid,
    output logic [UW-1:0]   umi_out_packet,
    input  logic            umi_out_ready
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] S_UNLOCKED = 1'b0;
    localparam logic [0:0] S_LOCKED   = 1'b1;

    logic [0:0]    r_state;
    logic [0:0]    w_state_next;
    logic [IW-1:0] r_lock_idx;
    logic [IW-1:0] r_ptr;
    logic          r_out_valid;
    logic [UW-1:0] r_out_packet;

    logic          w_locked;
    logic          w_load;
    logic          w_rr_mode;
    logic [N-1:0]  w_req;
    logic [N-1:0]  w_fix_grant;
    logic [N-1:0]  w_rr_grant;
    logic [N-1:0]  w_mode_grant;
    logic [N-1:0]  w_arb_grant;
    logic [N-1:0]  w_grant;
    logic [N-1:0]  w_ready;
    logic          w_fix_found;
    logic          w_rr_found;
    logic [IW-1:0] w_rr_idx;
    logic [IW-1:0] w_acc_idx;
    logic          w_accept;
    logic          w_acc_last;
    logic [UW-1:0] w_sel_packet;

    assign w_load    = ~r_out_valid | umi_out_ready;
    assign w_req     = umi_in_valid & ~mask;
    assign w_rr_mode = (mode == 2'b01);

    always_comb begin
        w_fix_grant = '0;
        w_fix_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (w_req[i] && !w_fix_found) begin
                w_fix_grant[i] = 1'b1;
                w_fix_found    = 1'b1;
            end
        end
    end

    // Search upward from the pointer, wrapping past N-1 back to 0.
    always_comb begin
        w_rr_grant = '0;
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_rr_idx = IW'((int'(r_ptr) + k) % N);
            if (w_req[w_rr_idx] && !w_rr_found) begin
                w_rr_grant[w_rr_idx] = 1'b1;
                w_rr_found           = 1'b1;
            end
        end
    end

    assign w_mode_grant = w_rr_mode ? w_rr_grant : w_fix_grant;

`ifdef UMI_MUX_STARVE_EN
    localparam int CW = $clog2(STARVE + 1);

    logic [CW-1:0] r_starve [N];
    logic [N-1:0]  w_starved;
    logic [N-1:0]  w_starve_grant;
    logic          w_starve_found;

    always_comb begin
        w_starved      = '0;
        w_starve_grant = '0;
        w_starve_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_starved[i] = w_req[i] && (r_starve[i] == CW'(STARVE));
            if (w_starved[i] && !w_starve_found) begin
                w_starve_grant[i] = 1'b1;
                w_starve_found    = 1'b1;
            end
        end
    end

    assign w_arb_grant = w_starve_found ? w_starve_grant : w_mode_grant;

    // Counts only arbitration rounds actually lost to another input.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!nreset) begin
                r_starve[i] <= '0;
            end else if (w_grant[i] || !w_req[i]) begin
                r_starve[i] <= '0;
            end else if (!w_locked && w_load && (|w_grant) &&
                         (r_starve[i] != CW'(STARVE))) begin
                r_starve[i] <= r_starve[i] + 1'b1;
            end
        end
    end
`else
    assign w_arb_grant = w_mode_grant;
`endif

    assign w_grant      = w_locked ? (N'(1) << r_lock_idx) : w_arb_grant;
    assign w_ready      = w_load ? w_grant : '0;
    assign umi_in_ready = nreset ? w_ready : '0;
    assign w_accept     = |(umi_in_valid & umi_in_ready);

    always_comb begin
        w_acc_idx    = '0;
        w_sel_packet = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant[i]) begin
                w_acc_idx    = IW'(i);
                w_sel_packet = umi_in_packet[i*UW +: UW];
            end
        end
    end

    assign w_acc_last = umi_in_last[w_acc_idx];

    // Lock state machine: state register / next state / output.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state <= S_UNLOCKED;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_UNLOCKED: if (w_accept && !w_acc_last) w_state_next = S_LOCKED;
            S_LOCKED:   if (w_accept &&  w_acc_last) w_state_next = S_UNLOCKED;
            default:    w_state_next = S_UNLOCKED;
        endcase
    end

    always_comb begin
        w_locked = (r_state == S_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_lock_idx <= '0;
            r_ptr      <= '0;
        end else begin
            if (w_accept && !w_locked) begin
                r_lock_idx <= w_acc_idx;
            end
            if (w_accept && w_acc_last && w_rr_mode) begin
                r_ptr <= (w_acc_idx == IW'(N - 1)) ? '0 : w_acc_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_out_valid  <= 1'b0;
            r_out_packet <= '0;
        end else if (w_load) begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_out_packet <= w_sel_packet;
            end
        end
    end

    assign umi_out_valid  = r_out_valid;
    assign umi_out_packet = r_out_packet;

endmodule
`default_nettype wire

// File: tb/tb_umi_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_umi_mux_rr
// Purpose  : Scoreboard bench for umi_mux_rr with directed and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_umi_mux_rr;
    localparam int UW = 64;
    localparam int N  = 4;

    logic            clk = 1'b0;
    logic            nreset;
    logic [1:0]      mode;
    logic [N-1:0]    mask;
    logic [N-1:0]    umi_in_valid;
    logic [N-1:0]    umi_in_last;
    logic [N*UW-1:0] umi_in_packet;
    logic [N-1:0]    umi_in_ready;
    logic            umi_out_valid;
    logic [UW-1:0]   umi_out_packet;
    logic            umi_out_ready;

    int checks   = 0;
    int failures = 0;

    logic [UW-1:0] sb [$];
    bit  m_locked;
    bit  m_outv;
    bit  rst_prev;
    int  m_owner;
    int  m_ptr;
    int  last_acc;
    int  seq = 0;
    int  grants [N];

    umi_mux_rr #(.UW(UW), .N(N), .STARVE(16)) dut (
        .clk            (clk),
        .nreset         (nreset),
        .mode           (mode),
        .mask           (mask),
        .umi_in_valid   (umi_in_valid),
        .umi_in_last    (umi_in_last),
        .umi_in_packet  (umi_in_packet),
        .umi_in_ready   (umi_in_ready),
        .umi_out_valid  (umi_out_valid),
        .umi_out_packet (umi_out_packet),
        .umi_out_ready  (umi_out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic new_pkt(int i);
        seq++;
        umi_in_packet[i*UW +: UW] = {8'(i), 24'(seq), 32'($urandom())};
    endtask

    // Reference: one cycle of the mux at transaction level, evaluated on the
    // inputs the caller has just driven; returns with inputs open for change.
    task automatic step();
        int g;
        bit load;
        bit acc;
        logic [N-1:0] req;
        logic [N-1:0] er;
        #1;
        last_acc = -1;
        if (!nreset) begin
            check("rst_in_ready", umi_in_ready, '0);
            if (rst_prev) begin
                check("rst_out_valid", umi_out_valid, 1'b0);
                check("rst_out_packet", umi_out_packet, '0);
            end
            sb.delete();
            m_locked = 0;
            m_outv   = 0;
            m_ptr    = 0;
            rst_prev = 1;
        end else begin
            rst_prev = 0;
            check("out_valid", umi_out_valid, m_outv);
            req  = umi_in_valid & ~mask;
            load = !m_outv || umi_out_ready;
            g    = -1;
            if (m_locked) begin
                g = m_owner;
            end else if (req != 0) begin
                if (mode == 2'b01) begin
                    for (int k = 0; k < N; k++)
                        if (g < 0 && req[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                end else begin
                    for (int k = N - 1; k >= 0; k--)
                        if (req[k]) g = k;
                end
            end
            er = (load && g >= 0) ? N'(1 << g) : '0;
            check("in_ready", umi_in_ready, er);
            acc = load && g >= 0 && umi_in_valid[g];
            if (acc) begin
                sb.push_back(umi_in_packet[g*UW +: UW]);
                grants[g]++;
                last_acc = g;
                if (umi_in_last[g]) begin
                    m_locked = 0;
                    if (mode == 2'b01) m_ptr = (g + 1) % N;
                end else begin
                    m_locked = 1;
                    m_owner  = g;
                end
            end
            if (load) m_outv = acc;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output handshake must match the oldest expected beat.
    initial begin
        forever begin
            @(negedge clk);
            if (nreset === 1'b1 && umi_out_valid === 1'b1 && umi_out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_unexpected actual=%0h expected=none", umi_out_packet);
                end else begin
                    check("out_packet", umi_out_packet, sb.pop_front());
                end
            end
        end
    end

    initial begin
        int order [$];
        int g3;
        int g1;
        logic [UW-1:0] held;
        for (int i = 0; i < N; i++) grants[i] = 0;
        rst_prev = 0;
        nreset = 1'b0;
        mode = 2'b00;
        mask = '0;
        umi_in_valid = '1;
        umi_in_last = '1;
        umi_out_ready = 1'b1;
        for (int i = 0; i < N; i++) new_pkt(i);
        @(posedge clk);
        #1;

        // Reset with all inputs valid, then first grant right after release.
        repeat (3) step();
        nreset = 1'b1;
        step();
        check("first_grant", last_acc, 0);
        new_pkt(0);

        // Fixed priority: input 1 beats input 3 until 1 is masked.
        umi_in_valid = 4'b1010;
        g1 = grants[1];
        g3 = grants[3];
        repeat (6) begin
            step();
            if (last_acc >= 0) new_pkt(last_acc);
        end
        check("fixed_served1", grants[1] - g1, 6);
        check("fixed_starved3", grants[3] - g3, 0);
        mask = 4'b0010;
        step();
        check("fixed_mask_moves", last_acc, 3);
        if (last_acc >= 0) new_pkt(last_acc);
        mask = '0;

        // Round-robin, pointer still 0 (fixed mode never moves it).
        mode = 2'b01;
        umi_in_valid = '1;
        for (int n = 0; n < 5; n++) begin
            step();
            order.push_back(last_acc);
            if (last_acc >= 0) new_pkt(last_acc);
        end
        check("rr_order0", order[0], 0);
        check("rr_order1", order[1], 1);
        check("rr_order2", order[2], 2);
        check("rr_order3", order[3], 3);
        check("rr_order4", order[4], 0);

        // Lock: input 2 sends 3 beats while input 0 waits; mask does not break it.
        order.delete();
        umi_in_valid = 4'b0101;
        umi_in_last  = 4'b1011;
        step(); order.push_back(last_acc); new_pkt(2);
        mask = 4'b0100;
        step(); order.push_back(last_acc); new_pkt(2);
        umi_in_last = 4'b1111;
        step(); order.push_back(last_acc); new_pkt(2);
        mask = '0;
        umi_in_valid = 4'b0001;
        step(); order.push_back(last_acc); new_pkt(0);
        check("lock_beat_a", order[0], 2);
        check("lock_beat_b", order[1], 2);
        check("lock_beat_c", order[2], 2);
        check("lock_then_0", order[3], 0);

        // Backpressure: output held, no input ready, then resumes same cycle.
        mode = 2'b00;
        umi_in_valid = '1;
        step();
        if (last_acc >= 0) new_pkt(last_acc);
        umi_out_ready = 1'b0;
        held = umi_out_packet;
        repeat (5) begin
            step();
            check("bp_no_accept", last_acc, -1);
            check("bp_packet_stable", umi_out_packet, held);
        end
        umi_out_ready = 1'b1;
        step();
        check("bp_resume_load", last_acc, 0);
        if (last_acc >= 0) new_pkt(last_acc);

`ifndef UMI_MUX_STARVE_EN
        // Without the starvation option input 3 never wins against input 0.
        umi_in_valid = 4'b1001;
        g3 = grants[3];
        repeat (30) begin
            step();
            if (last_acc >= 0) new_pkt(last_acc);
        end
        check("no_starve_override", grants[3] - g3, 0);
`endif

        // Random traffic, occasional mid-stream resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 49) == 0) mode = 2'($urandom());
            if ($urandom_range(0, 19) == 0) mask = N'($urandom());
            umi_in_valid  = N'($urandom());
            umi_out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 399) == 0) begin
                nreset = 1'b0;
                umi_out_ready = 1'b0;
            end else begin
                nreset = 1'b1;
            end
            step();
            if (last_acc >= 0) begin
                new_pkt(last_acc);
                umi_in_last[last_acc] = ($urandom_range(0, 2) != 0);
            end
        end

        // Drain and confirm nothing was lost.
        nreset = 1'b1;
        umi_in_valid = '0;
        umi_out_ready = 1'b1;
        repeat (4) step();
        check("drain_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
